// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared pipeline header types: opcodes, ALU/MDU operations and the
// ID/EX control bundle carried from decode into execute.
package pipeline_hdrs;

    typedef enum logic [6:0] {
        R_TYPE     = 7'b0110011,
        I_TYPE     = 7'b0010011,
        L_TYPE     = 7'b0000011,
        S_TYPE     = 7'b0100011,
        B_TYPE     = 7'b1100011,
        LUI_TYPE   = 7'b0110111,
        AUIPC_TYPE = 7'b0010111,
        JAL_TYPE   = 7'b1101111,
        JALR_TYPE  = 7'b1100111,
        CSR_TYPE   = 7'b1110011
    } opcode_type_e;

    typedef enum logic [3:0] {
        ALU_NULL, ALU_ADD, ALU_SUB, ALU_SLL,
        ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE, SEQ_BUSY, SEQ_DONE
    } seq_state_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       reg_wr;
        logic       sel_a;
        logic       sel_b;
        logic [2:0] rd_ctrl;
        logic [2:0] wr_ctrl;
        logic [1:0] wb_sel;
        logic [2:0] br_type;
        logic       is_jump;
        logic       is_mret;
        logic       csr_wr_req;
        logic       csr_reg_rd;
    } ctrl_bundle_t;

    localparam logic [2:0] RD_NONE = 3'h3;
    localparam logic [2:0] WR_NONE = 3'h7;
    localparam logic [2:0] BR_NONE = 3'b011;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [6:0] F7_MRET   = 7'h18;

    localparam ctrl_bundle_t CTRL_NOP = '{
        alu_op:     ALU_NULL,
        reg_wr:     1'b0,
        sel_a:      1'b0,
        sel_b:      1'b0,
        rd_ctrl:    RD_NONE,
        wr_ctrl:    WR_NONE,
        wb_sel:     WB_ALU,
        br_type:    BR_NONE,
        is_jump:    1'b0,
        is_mret:    1'b0,
        csr_wr_req: 1'b0,
        csr_reg_rd: 1'b0
    };

    // Base integer op for a func3 (alternate func7 forms handled by caller)
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        alu_op_e op;
        unique case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_mdu_seq.sv
// Multi-cycle MUL/DIV sequencer: counts EX occupancy, holds the front end
// while busy and emits start / writeback pulses.
module mdu_seq
    import pipeline_hdrs::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    input  logic flush,
    output logic busy,
    output logic wb_pulse,
    output logic start_pulse
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam bit MUL_ONE = (MUL_CYCLES == 1);
    localparam bit DIV_ONE = (DIV_CYCLES == 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] launch_cnt;
    seq_state_e       launch_st;
    logic             start_q;

    assign launch_cnt = is_div ? DIV_LOAD : MUL_LOAD;
    assign launch_st  = (is_div ? DIV_ONE : MUL_ONE) ? SEQ_DONE : SEQ_BUSY;

    // State, counter and start pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start && !flush;
        end
    end

    // Next state: launch, count down, single DONE cycle; flush aborts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = launch_st;
                    cnt_d   = launch_cnt;
                end
            end
            SEQ_BUSY: begin
                if (cnt_q == '0) state_d = SEQ_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
                if (start) begin
                    state_d = launch_st;
                    cnt_d   = launch_cnt;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
        end
    end

    assign busy        = (state_q == SEQ_BUSY);
    assign wb_pulse    = (state_q == SEQ_DONE) && !flush;
    assign start_pulse = start_q;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Registered ID-stage decode with RV32M support, ID/EX control register
// with stall/flush, and front-end hold for multi-cycle MUL/DIV.
module ctrl_pipe_unit
    import pipeline_hdrs::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  opcode_type_e opcode,
    input  logic [2:0]   func3,
    input  logic [6:0]   func7,
    input  logic         stall_in,
    input  logic         flush,
    output ctrl_bundle_t ex_ctrl,
    output logic         ex_valid,
    output logic         ex_illegal,
    output mdu_op_e      mdu_op,
    output logic         mdu_start,
    output logic         mdu_wb,
    output logic         stall_out
);

    ctrl_bundle_t dec;
    logic         dec_ill;
    logic         dec_m;
    mdu_op_e      dec_mop;
    logic         seq_busy;
    logic         load_en;
    logic         seq_start;

    // Instruction decode; anything unrecognised collapses to NOP + illegal
    always_comb begin
        dec     = CTRL_NOP;
        dec_ill = 1'b0;
        dec_m   = 1'b0;
        dec_mop = MDU_MUL;
        unique case (1'b1)
            opcode == R_TYPE: begin
                dec.reg_wr = 1'b1;
                if (ENABLE_M && func7 == F7_MULDIV) begin
                    dec_m   = 1'b1;
                    dec_mop = mdu_op_e'(func3);
                end else if (func7 == F7_BASE) begin
                    dec.alu_op = base_alu(func3);
                end else if (func7 == F7_ALT && func3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (func7 == F7_ALT && func3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            opcode == I_TYPE: begin
                dec.reg_wr = 1'b1;
                dec.sel_b  = 1'b1;
                dec.alu_op = base_alu(func3);
                if (func3 == 3'b001 && func7 != F7_BASE) dec_ill = 1'b1;
                if (func3 == 3'b101) begin
                    if (func7 == F7_ALT)       dec.alu_op = ALU_SRA;
                    else if (func7 != F7_BASE) dec_ill    = 1'b1;
                end
            end
            opcode == L_TYPE: begin
                dec.alu_op  = ALU_ADD;
                dec.reg_wr  = 1'b1;
                dec.sel_b   = 1'b1;
                dec.rd_ctrl = func3;
                dec.wb_sel  = WB_MEM;
                dec_ill = (func3 == 3'b011) || (func3[2:1] == 2'b11);
            end
            opcode == S_TYPE: begin
                dec.alu_op  = ALU_ADD;
                dec.sel_b   = 1'b1;
                dec.wr_ctrl = func3;
                dec_ill = (func3 > 3'b010);
            end
            opcode == B_TYPE: begin
                dec.alu_op  = ALU_SUB;
                dec.br_type = func3;
                dec_ill = (func3[2:1] == 2'b01);
            end
            opcode == LUI_TYPE: begin
                dec.alu_op = ALU_PASSB;
                dec.reg_wr = 1'b1;
                dec.sel_b  = 1'b1;
            end
            opcode == AUIPC_TYPE: begin
                dec.alu_op = ALU_ADD;
                dec.reg_wr = 1'b1;
                dec.sel_a  = 1'b1;
                dec.sel_b  = 1'b1;
            end
            opcode == JAL_TYPE: begin
                dec.alu_op  = ALU_ADD;
                dec.reg_wr  = 1'b1;
                dec.sel_a   = 1'b1;
                dec.sel_b   = 1'b1;
                dec.wb_sel  = WB_PC4;
                dec.is_jump = 1'b1;
            end
            opcode == JALR_TYPE: begin
                dec.alu_op  = ALU_ADD;
                dec.reg_wr  = 1'b1;
                dec.sel_b   = 1'b1;
                dec.wb_sel  = WB_PC4;
                dec.is_jump = 1'b1;
                dec_ill = (func3 != 3'b000);
            end
            opcode == CSR_TYPE: begin
                if (func3 == 3'b001) begin
                    dec.reg_wr     = 1'b1;
                    dec.wb_sel     = WB_CSR;
                    dec.csr_wr_req = 1'b1;
                    dec.csr_reg_rd = 1'b1;
                end else if (func3 == 3'b000 && func7 == F7_MRET) begin
                    dec.is_mret = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec     = CTRL_NOP;
            dec_m   = 1'b0;
            dec_mop = MDU_MUL;
        end
    end

    assign load_en   = !flush && !stall_in && !seq_busy;
    assign seq_start = load_en && id_valid && dec_m;

    // ID/EX register: flush beats stall/busy hold beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            mdu_op     <= MDU_MUL;
        end else if (flush) begin
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            mdu_op     <= MDU_MUL;
        end else if (load_en) begin
            ex_ctrl    <= dec;
            ex_valid   <= id_valid;
            ex_illegal <= dec_ill && id_valid;
            mdu_op     <= dec_mop;
        end
    end

    mdu_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (seq_start),
        .is_div      (func3[2]),
        .flush       (flush),
        .busy        (seq_busy),
        .wb_pulse    (mdu_wb),
        .start_pulse (mdu_start)
    );

    assign stall_out = seq_busy;

endmodule
